// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Sequencer for the shared multiply and divide units of the multicycle CPU.
// It accepts a one-cycle start request from the main control FSM, pulses the
// start control of the selected unit, and counts that unit's fixed latency.
// It then issues one HI/LO write with the matching mux selects and reports
// completion.
//
// Optional feature macro: MULDIV_DIVZERO_CHECK_EN
//   Defined   : a divide with divisor == 0 is trapped in IDLE. The block goes
//               to DZ and pulses div_zero/done. The divider is never started
//               and HI/LO is not written.
//   Undefined : no trap. div_zero is tied low, and a divide by zero runs the
//               full DIV_CYCLES like any other divide.
//
// Parameters
//   MULT_CYCLES : multiplier latency in cycles (>= 2)
//   DIV_CYCLES  : divider latency in cycles (>= 2)
//   CNT_W       : counter width, must hold max(MULT_CYCLES, DIV_CYCLES) - 1
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   start_mult  in   multiply request (sampled in IDLE only)
//   start_div   in   divide request (sampled in IDLE only; mult has priority)
//   divisor     in   [31:0] B register value, used for the zero check
//   mult_ctrl   out  one-cycle start pulse to the multiplier
//   div_ctrl    out  one-cycle start pulse to the divider
//   hilo_write  out  HI/LO load enable
//   hi_src      out  HI mux select (0 = mult, 1 = div)
//   lo_src      out  LO mux select (0 = mult, 1 = div)
//   busy        out  high in every state except IDLE
//   done        out  one-cycle completion pulse
//   div_zero    out  one-cycle divide-by-zero exception pulse
//
// All outputs come straight from flops. The next-state logic computes each
// output's value for the state being entered, so a pulse lines up exactly
// with the state it belongs to.
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] divisor,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic        hilo_write,
    output logic        hi_src,
    output logic        lo_src,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

`ifdef MULDIV_DIVZERO_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2,
        S_DZ   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;
`endif

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic             op_q, op_d;          // 0 = mult, 1 = div
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mult_ctrl_d, div_ctrl_d, hilo_write_d, src_d, busy_d, done_d;

`ifdef MULDIV_DIVZERO_CHECK_EN
    logic div_zero_d;
    logic divisor_is_zero;
    assign divisor_is_zero = (divisor == 32'h0);
`else
    // The zero check is absent in this build, so divisor has no consumer.
    logic divisor_unused;
    assign divisor_unused = |divisor;
    assign div_zero       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        mult_ctrl_d  = 1'b0;
        div_ctrl_d   = 1'b0;
        hilo_write_d = 1'b0;
        src_d        = hi_src;             // selects hold outside WB
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef MULDIV_DIVZERO_CHECK_EN
        div_zero_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_mult) begin
                    state_d     = S_RUN;
                    op_d        = 1'b0;
                    cnt_d       = MULT_LOAD;
                    mult_ctrl_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (start_div) begin
`ifdef MULDIV_DIVZERO_CHECK_EN
                    if (divisor_is_zero) begin
                        state_d    = S_DZ;
                        div_zero_d = 1'b1;
                        done_d     = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        state_d    = S_RUN;
                        op_d       = 1'b1;
                        cnt_d      = DIV_LOAD;
                        div_ctrl_d = 1'b1;
                        busy_d     = 1'b1;
                    end
`else
                    state_d    = S_RUN;
                    op_d       = 1'b1;
                    cnt_d      = DIV_LOAD;
                    div_ctrl_d = 1'b1;
                    busy_d     = 1'b1;
`endif
                end
            end

            S_RUN: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d      = S_WB;
                    hilo_write_d = 1'b1;
                    done_d       = 1'b1;
                    src_d        = op_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_WB: begin
                state_d = S_IDLE;
            end

`ifdef MULDIV_DIVZERO_CHECK_EN
            S_DZ: begin
                state_d = S_IDLE;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            cnt_q      <= '0;
            mult_ctrl  <= 1'b0;
            div_ctrl   <= 1'b0;
            hilo_write <= 1'b0;
            hi_src     <= 1'b0;
            lo_src     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            mult_ctrl  <= mult_ctrl_d;
            div_ctrl   <= div_ctrl_d;
            hilo_write <= hilo_write_d;
            hi_src     <= src_d;
            lo_src     <= src_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef MULDIV_DIVZERO_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_zero <= 1'b0;
        end else begin
            div_zero <= div_zero_d;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Directed bench for muldiv_ctrl with default parameters (32-cycle units).
// A table of operations, each holding its inputs and the expected behaviour,
// is walked in a loop. Every cycle of an operation compares the whole output
// bundle against the expected bundle. A hand-written sequence covers an
// asynchronous reset in the middle of RUN.
// Output bundle bit order:
//   {mult_ctrl, div_ctrl, hilo_write, hi_src, lo_src, busy, done, div_zero}
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam int LAT = 32;

`ifdef MULDIV_DIVZERO_CHECK_EN
    localparam bit DZEN = 1'b1;
`else
    localparam bit DZEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] divisor = 32'h0;
    logic        mult_ctrl, div_ctrl, hilo_write, hi_src, lo_src;
    logic        busy, done, div_zero;

    muldiv_ctrl #(
        .MULT_CYCLES (32),
        .DIV_CYCLES  (32),
        .CNT_W       (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .divisor    (divisor),
        .mult_ctrl  (mult_ctrl),
        .div_ctrl   (div_ctrl),
        .hilo_write (hilo_write),
        .hi_src     (hi_src),
        .lo_src     (lo_src),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    logic last_op = 1'b0;   // expected value of hi_src/lo_src outside WB

    typedef struct {
        string       name;
        logic        sm;       // start_mult
        logic        sd;       // start_div
        logic [31:0] dv;       // divisor
        logic        extra;    // pulse start_mult again during RUN
        logic        e_start;  // an operation is expected to begin
        logic        e_op;     // expected op (0 mult, 1 div)
        logic        e_dz;     // expected divide-by-zero trap
    } vec_t;

    vec_t vecs[9];

    function automatic logic [7:0] outs();
        return {mult_ctrl, div_ctrl, hilo_write, hi_src, lo_src, busy, done, div_zero};
    endfunction

    function automatic logic [7:0] pack(logic mc, logic dc, logic hw, logic src,
                                        logic bz, logic dn, logic dz);
        return {mc, dc, hw, src, src, bz, dn, dz};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle. Drives the request for
    // one cycle, then checks every cycle until the block is idle again.
    task automatic run_vec(input vec_t v);
        logic [7:0] exp;
        start_mult = v.sm;
        start_div  = v.sd;
        divisor    = v.dv;
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        if (!v.e_start) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s k=%0d", v.name, k), outs(),
                      pack(0, 0, 0, last_op, 0, 0, 0));
                @(posedge clk); #1;
            end
        end else if (v.e_dz) begin
            check($sformatf("%s k=0", v.name), outs(), pack(0, 0, 0, last_op, 1, 1, 1));
            @(posedge clk); #1;
            check($sformatf("%s k=1", v.name), outs(), pack(0, 0, 0, last_op, 0, 0, 0));
        end else begin
            for (int k = 0; k <= LAT + 1; k++) begin
                exp = pack((k == 0) && !v.e_op,
                           (k == 0) && v.e_op,
                           (k == LAT),
                           (k >= LAT) ? v.e_op : last_op,
                           (k <= LAT),
                           (k == LAT),
                           1'b0);
                check($sformatf("%s k=%0d", v.name, k), outs(), exp);
                start_mult = v.extra && (k % 2 == 1) && (k <= LAT - 2);
                @(posedge clk); #1;
            end
            start_mult = 1'b0;
            last_op = v.e_op;
        end
    endtask

    int hw_seen;

    initial begin
        //           name            sm sd dv      ex  st  op  dz
        vecs[0] = '{"mult",          1, 0, 32'd5,  0,  1,  0,  0};
        vecs[1] = '{"div7",          0, 1, 32'd7,  0,  1,  1,  0};
        vecs[2] = '{"both",          1, 1, 32'd3,  0,  1,  0,  0};
        vecs[3] = '{"idle",          0, 0, 32'd0,  0,  0,  0,  0};
        vecs[4] = '{"div0",          0, 1, 32'd0,  0,  1,  1,  DZEN};
        vecs[5] = '{"mult_extra",    1, 0, 32'd9,  1,  1,  0,  0};
        vecs[6] = '{"both_div0",     1, 1, 32'd0,  0,  1,  0,  0};
        vecs[7] = '{"div_extra",     0, 1, 32'hFFFF_FFFF, 1, 1, 1, 0};
        vecs[8] = '{"div0_again",    0, 1, 32'd0,  0,  1,  1,  DZEN};

        // Reset state, checked while reset is held.
        #1;
        check("reset_state", outs(), 8'h00);
        @(posedge clk); #1;
        check("reset_held", outs(), 8'h00);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a multiply.
        start_mult = 1'b1;
        @(posedge clk); #1;
        start_mult = 1'b0;
        check("rst_seq accept", outs(), pack(1, 0, 0, last_op, 1, 0, 0));
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_seq async drop", outs(), 8'h00);
        last_op = 1'b0;
        hw_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (hilo_write) hw_seen++;
        end
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (hilo_write || done || busy) hw_seen++;
        end
        check_int("rst_seq no writeback", hw_seen, 0);
        check("rst_seq idle after", outs(), 8'h00);

        // A fresh operation after reset release.
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
